judge_client: RTL and testbench

JUDGE_CLIENT -- requirements
Module: judge_client

---
 rtl/judge_client_pkg.sv | 10 +
 rtl/judge_client_if.sv | 22 ++
 rtl/judge_client_chan.sv | 92 +++++++++
 rtl/judge_client.sv | 45 ++++
 tb/tb_judge_client.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/judge_client_pkg.sv
// Shared types and sizing for the judge client: channel FSM states and
// the pending / wait counter widths.
package judge_client_pkg;
  typedef enum logic [1:0] {IDLE, REQ, BUSY, REL} chan_state_e;

  localparam int NUM_CH   = 4;
  localparam int PEND_W   = 4;
  localparam int PEND_MAX = 15;
  localparam int WAIT_W   = 8;
endpackage

// File: rtl/judge_client_if.sv
// Job intake, arbiter handshake and status flags of the judge client.
interface judge_client_if;
  import judge_client_pkg::*;

  logic [NUM_CH-1:0] job;
  logic [NUM_CH-1:0] job_rdy;
  logic              gnt3, gnt2, gnt1, gnt0;
  logic              req3, req2, req1, req0;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] starve;
  logic              proto_err;

  modport slave (
    input  job, gnt3, gnt2, gnt1, gnt0,
    output job_rdy, req3, req2, req1, req0, done, starve, proto_err
  );

  modport master (
    output job, gnt3, gnt2, gnt1, gnt0,
    input  job_rdy, req3, req2, req1, req0, done, starve, proto_err
  );
endinterface

// File: rtl/judge_client_chan.sv
// One client channel: pending-job count, IDLE/REQ/BUSY/REL FSM, beat and
// wait counters. Flags a grant gap in BUSY for the top-level protocol check.
module judge_client_chan
  import judge_client_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic job,
  input  logic gnt,
  output logic job_rdy,
  output logic req,
  output logic done,
  output logic starve,
  output logic gap
);
  localparam logic [3:0]        LAST_BEAT = 4'(BURST - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT);
  localparam logic [PEND_W-1:0] PEND_TOP  = PEND_W'(PEND_MAX);

  chan_state_e       state, state_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic [3:0]        beat, beat_nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_nxt;
  logic              take, start;

  assign job_rdy = (pend != PEND_TOP);
  assign take    = job & job_rdy;
  assign gap     = (state == BUSY) & ~gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pend   <= '0;
      beat   <= '0;
      wcnt   <= '0;
      starve <= 1'b0;
      req    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      beat   <= beat_nxt;
      wcnt   <= wcnt_nxt;
      starve <= starve | (wcnt_nxt >= WAIT_LIM);
      req    <= (state_nxt == REQ) || (state_nxt == BUSY);
      done   <= (state_nxt == REL);
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    start     = 1'b0;
    case (state)
      IDLE: if (pend != '0) state_nxt = REQ;
      REQ: if (gnt) begin
        // the granting edge is beat 1
        start = 1'b1;
        if (BURST == 1) begin
          state_nxt = REL;
          beat_nxt  = '0;
        end else begin
          state_nxt = BUSY;
          beat_nxt  = 4'd1;
        end
      end
      BUSY: if (gnt) begin
        if (beat == LAST_BEAT) begin
          state_nxt = REL;
          beat_nxt  = '0;
        end else begin
          beat_nxt = beat + 4'd1;
        end
      end
      REL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pend_nxt = pend;
    if (take && !start)      pend_nxt = pend + 1'b1;
    else if (!take && start) pend_nxt = pend - 1'b1;

    wcnt_nxt = '0;
    if (state == REQ && !gnt) wcnt_nxt = (wcnt == WAIT_SAT) ? wcnt : wcnt + 1'b1;
  end
endmodule

// File: rtl/judge_client.sv
// Four independent judge client channels plus the shared sticky
// grant-protocol checker.
module judge_client
  import judge_client_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  judge_client_if.slave  bus
);
  logic [NUM_CH-1:0] gnt, req, gap, job_rdy, done, starve;
  logic              multi, orphan, perr;

  assign gnt = {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
  assign {bus.req3, bus.req2, bus.req1, bus.req0} = req;
  assign bus.job_rdy   = job_rdy;
  assign bus.done      = done;
  assign bus.starve    = starve;
  assign bus.proto_err = perr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    judge_client_chan #(.BURST(BURST), .TIMEOUT(TIMEOUT)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .job     (bus.job[g]),
      .gnt     (gnt[g]),
      .job_rdy (job_rdy[g]),
      .req     (req[g]),
      .done    (done[g]),
      .starve  (starve[g]),
      .gap     (gap[g])
    );
  end

  // more than one grant bit set, or a grant to a channel not requesting
  assign multi  = (gnt & (gnt - 1'b1)) != '0;
  assign orphan = |(gnt & ~req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr <= 1'b0;
    else      perr <= perr | multi | orphan | (|gap);
  end
endmodule

// File: tb/tb_judge_client.sv
// Directed bench for judge_client; done pulses are matched against a
// scoreboard of expected completing channels.
module tb_judge_client;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_done[$];
  int   done_cnt[4] = '{0, 0, 0, 0};

  judge_client_if bus ();

  judge_client #(.BURST(4), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] reqv();
    return {bus.req3, bus.req2, bus.req1, bus.req0};
  endfunction

  task automatic set_gnt(input logic [3:0] g);
    {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0} = g;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.job = '0;
    set_gnt(4'b0000);
    step();
    step();
    rst = 1'b1;
  endtask

  // done-pulse monitor: each pulse must match the oldest expected channel
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.done[i] === 1'b1) begin
          done_cnt[i]++;
          if (exp_done.size() == 0) chk("done_unexpected", i, 32'hFFFF);
          else                      chk("done_chan", i, exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.job = '0;
    set_gnt(4'b0000);
    step();
    chk("rst_req", reqv(), 4'h0);
    chk("rst_done", bus.done, 4'h0);
    chk("rst_starve", bus.starve, 4'h0);
    chk("rst_perr", bus.proto_err, 1'b0);
    chk("rst_jobrdy", bus.job_rdy, 4'hF);
    step();
    rst = 1'b1;

    // single job on channel 0, grant held
    bus.job = 4'b0001;
    step();
    bus.job = '0;
    chk("t1_req_early", reqv(), 4'h0);
    step();
    chk("t1_req_up", reqv(), 4'b0001);
    exp_done.push_back(0);
    set_gnt(4'b0001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_busy_req", reqv(), 4'b0001);
      chk("t1_busy_done", bus.done, 4'h0);
    end
    step();
    chk("t1_done", bus.done, 4'b0001);
    chk("t1_rel_req", reqv(), 4'h0);
    chk("t1_rel_perr", bus.proto_err, 1'b0);
    step();
    chk("t1_done_off", bus.done, 4'h0);
    chk("t1_orphan_perr", bus.proto_err, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_idle_req", reqv(), 4'h0);
    end

    // pending saturation on channel 1
    do_reset();
    bus.job = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      chk("t2_jobrdy", bus.job_rdy[1], (i < 15) ? 1'b1 : 1'b0);
      if (i < 15) exp_done.push_back(1);
      step();
    end
    bus.job = '0;
    chk("t2_full", bus.job_rdy, 4'b1101);
    chk("t2_req", reqv(), 4'b0010);
    set_gnt(4'b0010);
    repeat (120) step();
    set_gnt(4'b0000);
    step();
    chk("t2_count", done_cnt[1], 15);
    chk("t2_jobrdy_back", bus.job_rdy, 4'hF);
    chk("t2_sb_empty", exp_done.size(), 0);

    // starvation on channel 2
    do_reset();
    bus.job = 4'b0100;
    step();
    bus.job = '0;
    step();
    chk("t3_req", reqv(), 4'b0100);
    repeat (15) step();
    chk("t3_starve_pre", bus.starve, 4'h0);
    step();
    chk("t3_starve", bus.starve, 4'b0100);
    exp_done.push_back(2);
    set_gnt(4'b0100);
    repeat (6) step();
    set_gnt(4'b0000);
    step();
    chk("t3_sticky", bus.starve, 4'b0100);
    chk("t3_sb_empty", exp_done.size(), 0);
    do_reset();
    chk("t3_cleared", bus.starve, 4'h0);

    // two grants in one cycle while both channels request
    bus.job = 4'b0011;
    step();
    bus.job = '0;
    step();
    chk("t4_req", reqv(), 4'b0011);
    chk("t4_perr_pre", bus.proto_err, 1'b0);
    set_gnt(4'b0011);
    step();
    set_gnt(4'b0000);
    chk("t4_multi", bus.proto_err, 1'b1);
    step();
    chk("t4_multi_sticky", bus.proto_err, 1'b1);

    // grant to a non-requesting channel
    do_reset();
    chk("t4_perr_clr", bus.proto_err, 1'b0);
    set_gnt(4'b1000);
    step();
    set_gnt(4'b0000);
    chk("t4_orphan", bus.proto_err, 1'b1);
    step();
    chk("t4_orphan_sticky", bus.proto_err, 1'b1);

    // grant gap mid-burst on channel 0
    do_reset();
    bus.job = 4'b0001;
    step();
    bus.job = '0;
    step();
    exp_done.push_back(0);
    set_gnt(4'b0001);
    step();
    step();
    chk("t5_perr_pre", bus.proto_err, 1'b0);
    set_gnt(4'b0000);
    repeat (3) step();
    chk("t5_paused_done", bus.done, 4'h0);
    chk("t5_paused_req", reqv(), 4'b0001);
    chk("t5_gap_perr", bus.proto_err, 1'b1);
    set_gnt(4'b0001);
    step();
    chk("t5_beat3", bus.done, 4'h0);
    step();
    set_gnt(4'b0000);
    chk("t5_done", bus.done, 4'b0001);
    step();
    chk("t5_sb_empty", exp_done.size(), 0);

    // asynchronous reset in the middle of a burst with a job queued
    do_reset();
    bus.job = 4'b0001;
    step();
    bus.job = '0;
    step();
    set_gnt(4'b0001);
    step();
    bus.job = 4'b0001;
    step();
    bus.job = '0;
    chk("t6_busy_req", reqv(), 4'b0001);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("t6_async_req", reqv(), 4'h0);
    set_gnt(4'b0000);
    step();
    chk("t6_jobrdy", bus.job_rdy, 4'hF);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t6_idle_req", reqv(), 4'h0);
      chk("t6_no_done", bus.done, 4'h0);
    end
    chk("t6_sb_empty", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
